// File: rtl/multi_port_scoreboard_pkg.sv
// Shared types and constants for the multi-port egress scoreboard.
package multi_port_scoreboard_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        NONE,
        MISMATCH,
        UNEXPECTED,
        OVERFLOW,
        TIMEOUT
    } err_code_e;

endpackage

// File: rtl/multi_port_scoreboard_if.sv
// Ingress/egress observation bus of the scoreboard: one ingress stream, NPORT egress streams.
interface multi_port_scoreboard_if #(
    parameter int DATA_W = 8,
    parameter int NPORT  = 4
);

    logic                       in_vld;
    logic [DATA_W-1:0]          in_data;
    logic [$clog2(NPORT)-1:0]   in_port;
    logic [NPORT-1:0]           out_vld;
    logic [NPORT*DATA_W-1:0]    out_data;

    modport master (
        output in_vld,
        output in_data,
        output in_port,
        output out_vld,
        output out_data
    );

    modport slave (
        input in_vld,
        input in_data,
        input in_port,
        input out_vld,
        input out_data
    );

endinterface

// File: rtl/sb_port_queue.sv
// One expected-packet FIFO with a head-of-queue age counter.
// push/pop are pre-qualified by the caller; this block never checks full/empty itself.
module sb_port_queue #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int MAX_LAT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              expired
);

    localparam int AW    = $clog2(DEPTH);
    localparam int AGE_W = $clog2(MAX_LAT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_LAT + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AGE_W-1:0]  age;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign expired = (age == AGE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (flush || pop || empty) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/multi_port_scoreboard.sv
// Multi-port scoreboard: routes ingress packets into per-port expected queues and
// checks each egress beat against the queue head, keeping sticky error state.
module multi_port_scoreboard
    import multi_port_scoreboard_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NPORT   = 4,
    parameter int DEPTH   = 16,
    parameter int MAX_LAT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      err_clr,
    multi_port_scoreboard_if.slave    bus,
    output logic                      err_mismatch,
    output logic                      err_unexpected,
    output logic                      err_overflow,
    output logic                      err_timeout,
    output logic [$clog2(NPORT)-1:0]  err_port,
    output logic [CNT_W-1:0]          mismatch_cnt,
    output logic                      idle
);

    localparam int PW = $clog2(NPORT);

    logic [NPORT-1:0]  q_empty;
    logic [NPORT-1:0]  q_full;
    logic [NPORT-1:0]  q_expired;
    logic [NPORT-1:0]  push_ok;
    logic [NPORT-1:0]  pop_ok;
    logic [NPORT-1:0]  mis_vec;
    logic [NPORT-1:0]  unexp_vec;
    logic [NPORT-1:0]  ovf_vec;
    logic [DATA_W-1:0] q_head [NPORT];

    logic              err_found;
    logic [PW-1:0]     first_port;
    logic [4:0]        mis_num;
    logic              flags_any;

    function automatic err_code_e classify(input logic mis, input logic unexp,
                                           input logic ovf, input logic tmo);
        if (mis)   return MISMATCH;
        if (unexp) return UNEXPECTED;
        if (ovf)   return OVERFLOW;
        if (tmo)   return TIMEOUT;
        return NONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-4){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Decisions use pre-push queue state, so a same-cycle push never rescues an empty-queue egress.
    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [DATA_W-1:0] egress;
        logic              hit;

        assign egress       = bus.out_data[p*DATA_W +: DATA_W];
        assign hit          = bus.in_vld && (bus.in_port == PW'(p)) && !flush;
        assign pop_ok[p]    = bus.out_vld[p] && !q_empty[p] && !flush;
        assign push_ok[p]   = hit && (!q_full[p] || pop_ok[p]);
        assign mis_vec[p]   = pop_ok[p] && (q_head[p] != egress);
        assign unexp_vec[p] = bus.out_vld[p] && q_empty[p] && !flush;
        assign ovf_vec[p]   = hit && q_full[p] && !pop_ok[p];

        sb_port_queue #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .MAX_LAT (MAX_LAT)
        ) u_queue (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .push    (push_ok[p]),
            .wdata   (bus.in_data),
            .pop     (pop_ok[p]),
            .head    (q_head[p]),
            .empty   (q_empty[p]),
            .full    (q_full[p]),
            .expired (q_expired[p])
        );
    end

    assign idle      = &q_empty;
    assign flags_any = err_mismatch | err_unexpected | err_overflow | err_timeout;

    // Descending scan so the lowest erring port is the last one written.
    always_comb begin
        err_found  = 1'b0;
        first_port = '0;
        mis_num    = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (classify(mis_vec[i], unexp_vec[i], ovf_vec[i], q_expired[i]) != NONE) begin
                err_found  = 1'b1;
                first_port = PW'(i);
            end
            mis_num = mis_num + 5'(mis_vec[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mismatch   <= 1'b0;
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
            err_timeout    <= 1'b0;
            err_port       <= '0;
            mismatch_cnt   <= '0;
        end else if (err_clr) begin
            err_mismatch   <= 1'b0;
            err_unexpected <= 1'b0;
            err_overflow   <= 1'b0;
            err_timeout    <= 1'b0;
            err_port       <= '0;
            mismatch_cnt   <= '0;
        end else begin
            err_mismatch   <= err_mismatch   | (|mis_vec);
            err_unexpected <= err_unexpected | (|unexp_vec);
            err_overflow   <= err_overflow   | (|ovf_vec);
            err_timeout    <= err_timeout    | (|q_expired);
            if (!flags_any && err_found) err_port <= first_port;
            mismatch_cnt   <= sat_add(mismatch_cnt, mis_num);
        end
    end

endmodule

// File: tb/tb_multi_port_scoreboard.sv
// Bench for multi_port_scoreboard: vector table plus hand sequences for overflow,
// full pass-through, timeout, flush and mid-traffic reset.
module tb_multi_port_scoreboard;

    localparam int DATA_W  = 8;
    localparam int NPORT   = 4;
    localparam int DEPTH   = 16;
    localparam int MAX_LAT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        err_clr;
    logic        err_mismatch;
    logic        err_unexpected;
    logic        err_overflow;
    logic        err_timeout;
    logic [1:0]  err_port;
    logic [15:0] mismatch_cnt;
    logic        idle;

    multi_port_scoreboard_if #(.DATA_W(DATA_W), .NPORT(NPORT)) bus ();

    multi_port_scoreboard #(
        .DATA_W  (DATA_W),
        .NPORT   (NPORT),
        .DEPTH   (DEPTH),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .err_clr        (err_clr),
        .bus            (bus),
        .err_mismatch   (err_mismatch),
        .err_unexpected (err_unexpected),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout),
        .err_port       (err_port),
        .mismatch_cnt   (mismatch_cnt),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        in_vld;
        logic [7:0]  in_data;
        logic [1:0]  in_port;
        logic [3:0]  out_vld;
        logic [31:0] out_data;
        logic        flush;
        logic        err_clr;
        logic [3:0]  exp_flags;   // {mismatch, unexpected, overflow, timeout}
        logic [1:0]  exp_port;
        logic [15:0] exp_cnt;
        logic        exp_idle;
    } vec_t;

    vec_t       exp_q [$];
    logic [7:0] sbq0 [$];
    vec_t       tbl [23];
    int         checks   = 0;
    int         failures = 0;

    function automatic vec_t mk(input string tag, input logic iv, input logic [7:0] id,
                                input logic [1:0] ip, input logic [3:0] ov, input logic [31:0] od,
                                input logic fl, input logic ec, input logic [3:0] ef,
                                input logic [1:0] ep, input logic [15:0] ecnt, input logic ei);
        vec_t v;
        v.tag = tag; v.in_vld = iv; v.in_data = id; v.in_port = ip;
        v.out_vld = ov; v.out_data = od; v.flush = fl; v.err_clr = ec;
        v.exp_flags = ef; v.exp_port = ep; v.exp_cnt = ecnt; v.exp_idle = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.in_vld   = 1'b0;
        bus.in_data  = '0;
        bus.in_port  = '0;
        bus.out_vld  = '0;
        bus.out_data = '0;
        flush        = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic run_cycle(input vec_t v);
        vec_t cmp;
        @(negedge clk);
        bus.in_vld   = v.in_vld;
        bus.in_data  = v.in_data;
        bus.in_port  = v.in_port;
        bus.out_vld  = v.out_vld;
        bus.out_data = v.out_data;
        flush        = v.flush;
        err_clr      = v.err_clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cmp = exp_q.pop_front();
        chk({cmp.tag, "_flags"}, 32'({err_mismatch, err_unexpected, err_overflow, err_timeout}),
            32'(cmp.exp_flags));
        chk({cmp.tag, "_port"}, 32'(err_port), 32'(cmp.exp_port));
        chk({cmp.tag, "_cnt"}, 32'(mismatch_cnt), 32'(cmp.exp_cnt));
        chk({cmp.tag, "_idle"}, 32'(idle), 32'(cmp.exp_idle));
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", 32'({err_mismatch, err_unexpected, err_overflow, err_timeout}), 32'h0);
        chk("reset_port", 32'(err_port), 32'h0);
        chk("reset_cnt", 32'(mismatch_cnt), 32'h0);
        chk("reset_idle", 32'(idle), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        //               tag            iv  data   pt ovld     odata        fl ec flags    pt cnt idle
        tbl[0]  = mk("io_push11",   1, 8'h11, 2, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[1]  = mk("io_push22",   1, 8'h22, 2, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[2]  = mk("io_push33",   1, 8'h33, 2, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[3]  = mk("io_pop11",    0, 8'h00, 0, 4'b0100, 32'h00110000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[4]  = mk("io_pop22",    0, 8'h00, 0, 4'b0100, 32'h00220000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[5]  = mk("io_pop33",    0, 8'h00, 0, 4'b0100, 32'h00330000, 0, 0, 4'b0000, 0, 0, 1);
        tbl[6]  = mk("mm_push",     1, 8'hA5, 1, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[7]  = mk("mm_pop",      0, 8'h00, 0, 4'b0010, 32'h00005A00, 0, 0, 4'b1000, 1, 1, 1);
        tbl[8]  = mk("mm_clr",      0, 8'h00, 0, 4'b0000, 32'h0,       0, 1, 4'b0000, 0, 0, 1);
        tbl[9]  = mk("dual_push0",  1, 8'h01, 0, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[10] = mk("dual_push3",  1, 8'h02, 3, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[11] = mk("dual_pop",    0, 8'h00, 0, 4'b1001, 32'hFE0000FF, 0, 0, 4'b1000, 0, 2, 1);
        tbl[12] = mk("dual_clr",    0, 8'h00, 0, 4'b0000, 32'h0,       0, 1, 4'b0000, 0, 0, 1);
        tbl[13] = mk("hazard",      1, 8'h77, 3, 4'b1000, 32'h77000000, 0, 0, 4'b0100, 3, 0, 0);
        tbl[14] = mk("hazard_pop",  0, 8'h00, 0, 4'b1000, 32'h77000000, 0, 0, 4'b0100, 3, 0, 1);
        tbl[15] = mk("hazard_clr",  0, 8'h00, 0, 4'b0000, 32'h0,       0, 1, 4'b0000, 0, 0, 1);
        tbl[16] = mk("fl_push",     1, 8'h12, 1, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[17] = mk("fl_flush",    1, 8'h34, 2, 4'b0010, 32'h0000EE00, 1, 0, 4'b0000, 0, 0, 1);
        tbl[18] = mk("fl_after",    0, 8'h00, 0, 4'b0010, 32'h00001200, 0, 0, 4'b0100, 1, 0, 1);
        tbl[19] = mk("fl_clr",      0, 8'h00, 0, 4'b0000, 32'h0,       0, 1, 4'b0000, 0, 0, 1);
        tbl[20] = mk("mix_push",    1, 8'hC3, 0, 4'b0000, 32'h0,       0, 0, 4'b0000, 0, 0, 0);
        tbl[21] = mk("mix_both",    1, 8'h3C, 1, 4'b0001, 32'h000000C3, 0, 0, 4'b0000, 0, 0, 0);
        tbl[22] = mk("mix_pop",     0, 8'h00, 0, 4'b0010, 32'h00003C00, 0, 0, 4'b0000, 0, 0, 1);

        for (int i = 0; i < 23; i++) run_cycle(tbl[i]);

        // Overflow: 16 pushes fill port 0, the 17th is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i + 8'h40);
            sbq0.push_back(d);
            run_cycle(mk("ovf_fill", 1, d, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 0));
        end
        run_cycle(mk("ovf_17th", 1, 8'hEE, 0, 4'b0000, 32'h0, 0, 0, 4'b0010, 0, 0, 0));
        for (int i = 0; i < DEPTH; i++) begin
            d = sbq0.pop_front();
            run_cycle(mk("ovf_drain", 0, 8'h00, 0, 4'b0001, 32'(d), 0, 0, 4'b0010, 0, 0,
                         (sbq0.size() == 0)));
        end
        run_cycle(mk("ovf_clr", 0, 8'h00, 0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 0, 1));

        // Full queue: simultaneous push and pop passes through without overflow.
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'(i + 8'h80);
            sbq0.push_back(d);
            run_cycle(mk("pt_fill", 1, d, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 0));
        end
        d = sbq0.pop_front();
        sbq0.push_back(8'h99);
        run_cycle(mk("pt_pushpop", 1, 8'h99, 0, 4'b0001, 32'(d), 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < DEPTH; i++) begin
            d = sbq0.pop_front();
            run_cycle(mk("pt_drain", 0, 8'h00, 0, 4'b0001, 32'(d), 0, 0, 4'b0000, 0, 0,
                         (sbq0.size() == 0)));
        end

        // Timeout: one packet left waiting on port 0.
        run_cycle(mk("to_push", 1, 8'h42, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 60; i++)
            run_cycle(mk("to_wait", 0, 8'h00, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 0));
        for (int k = 0; k < 10 && err_timeout !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        chk("to_set", 32'(err_timeout), 32'h1);
        chk("to_port", 32'(err_port), 32'h0);
        run_cycle(mk("to_clr", 0, 8'h00, 0, 4'b0000, 32'h0, 0, 1, 4'b0000, 0, 0, 0));
        run_cycle(mk("to_clrflush", 0, 8'h00, 0, 4'b0000, 32'h0, 1, 1, 4'b0000, 0, 0, 1));
        run_cycle(mk("to_after", 0, 8'h00, 0, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 1));

        // Flush with five pending packets keeps the sticky state.
        run_cycle(mk("fs_push", 1, 8'h10, 1, 4'b0000, 32'h0, 0, 0, 4'b0000, 0, 0, 0));
        run_cycle(mk("fs_mm", 0, 8'h00, 0, 4'b0010, 32'h00001100, 0, 0, 4'b1000, 1, 1, 1));
        for (int i = 0; i < 5; i++)
            run_cycle(mk("fs_pend", 1, 8'(8'hB0 + i), 2'(i), 4'b0000, 32'h0, 0, 0, 4'b1000, 1, 1, 0));
        run_cycle(mk("fs_flush", 0, 8'h00, 0, 4'b0000, 32'h0, 1, 0, 4'b1000, 1, 1, 1));
        run_cycle(mk("fs_push2a", 1, 8'h61, 2, 4'b0000, 32'h0, 0, 0, 4'b1000, 1, 1, 0));
        run_cycle(mk("fs_push2b", 1, 8'h62, 2, 4'b0000, 32'h0, 0, 0, 4'b1000, 1, 1, 0));

        // Reset asserted mid-burst, away from any clock edge.
        @(negedge clk);
        bus.in_vld  = 1'b1;
        bus.in_data = 8'h66;
        bus.in_port = 2'd2;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", 32'({err_mismatch, err_unexpected, err_overflow, err_timeout}), 32'h0);
        chk("rst_mid_port", 32'(err_port), 32'h0);
        chk("rst_mid_cnt", 32'(mismatch_cnt), 32'h0);
        chk("rst_mid_idle", 32'(idle), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_data = 8'h5C;
        bus.in_port = 2'd2;
        @(posedge clk);
        #1;
        chk("rst_first_push", 32'(idle), 32'h0);
        clear_inputs();
        run_cycle(mk("rst_pop", 0, 8'h00, 0, 4'b0100, 32'h005C0000, 0, 0, 4'b0000, 0, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_port_scoreboard.md
MULTI_PORT_SCOREBOARD -- requirements
Module: multi_port_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 The block SHALL have parameter NPORT, default 4, meaning number of egress ports checked; range 2..16.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning expected-packet entries per port; power of 2.
REQ-004 The block SHALL have parameter MAX_LAT, default 64, meaning the maximum number of cycles a packet may wait at the head of a port queue.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of all expected packets, the transmit-error abort.
REQ-008 The block SHALL have port err_clr, input, 1 bit: synchronous clear of sticky error state.
REQ-009 The block SHALL have port in_vld, input, 1 bit: ingress packet valid.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: ingress payload.
REQ-011 The block SHALL have port in_port, input, clog2(NPORT) bits: destination port of the ingress packet.
REQ-012 The block SHALL have port out_vld, input, NPORT bits: per-port egress valid.
REQ-013 The block SHALL have port out_data, input, NPORT*DATA_W bits: per-port egress payload; port p occupies bits [p*DATA_W +: DATA_W].
REQ-014 The block SHALL have port err_mismatch, output, 1 bit: sticky flag, egress payload differed from the expected payload.
REQ-015 The block SHALL have port err_unexpected, output, 1 bit: sticky flag, egress on a port with an empty queue.
REQ-016 The block SHALL have port err_overflow, output, 1 bit: sticky flag, ingress to a full port queue.
REQ-017 The block SHALL have port err_timeout, output, 1 bit: sticky flag, head-of-queue age exceeded MAX_LAT.
REQ-018 The block SHALL have port err_port, output, clog2(NPORT) bits: port of the first error since the last reset or clear.
REQ-019 The block SHALL have port mismatch_cnt, output, 16 bits: mismatch count, saturating at 0xFFFF.
REQ-020 The block SHALL have port idle, output, 1 bit: high when all port queues are empty.

Function
REQ-021 An in_vld cycle SHALL push in_data into the queue of port in_port; in_port values >= NPORT SHALL be ignored, with no push.
REQ-022 An out_vld[p] cycle SHALL pop queue p and compare its head with out_data slice p; any inequality SHALL set err_mismatch and increment mismatch_cnt.
REQ-023 Mismatches on several ports in the same cycle SHALL increment mismatch_cnt by the number of mismatching ports, saturating.
REQ-024 Comparison SHALL use queue state before any same-cycle push; egress on an empty queue SHALL set err_unexpected and perform no pop, even if a same-cycle push targets that port.
REQ-025 A push and a pop on the same full queue in the same cycle SHALL succeed with no overflow, and occupancy SHALL be unchanged.
REQ-026 A push to a full queue without a same-cycle pop SHALL set err_overflow, drop the packet, and leave the queue unchanged.
REQ-027 Each port SHALL keep a head-age counter: reset to 0 on pop, on flush, or while the queue is empty; otherwise increment by 1, saturating at MAX_LAT+1.
REQ-028 err_timeout SHALL be set in the cycle after any head-age counter reaches MAX_LAT+1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH, with a separate extra wrap bit distinguishing full from empty.
REQ-030 Error flags SHALL be registered, and SHALL assert one cycle after the offending input cycle.
REQ-031 err_port SHALL capture the lowest-numbered port erring in the cycle when the first flag sets, and SHALL hold until clear.
REQ-032 flush SHALL empty all queues and zero all age counters in one cycle; flush SHALL NOT change error flags or mismatch_cnt; in_vld and out_vld SHALL be ignored in a flush cycle.
REQ-033 err_clr SHALL zero all flags, err_port and mismatch_cnt; an error detected in the err_clr cycle SHALL be lost.
REQ-034 idle SHALL be combinational from the queue-empty flags.

Reset
REQ-035 While rst is high, all queues SHALL be empty, all age counters 0, all error flags 0, err_port 0, mismatch_cnt 0, and idle 1.
REQ-036 Reset assertion mid-traffic SHALL discard all state immediately; the first push SHALL be accepted on the first rising edge after rst deasserts.
REQ-037 Queue storage arrays SHALL NOT need reset.

Structure
REQ-038 A shared package multi_port_scoreboard_pkg SHALL hold the error-code enum (NONE, MISMATCH, UNEXPECTED, OVERFLOW, TIMEOUT) and the constant CNT_W=16.
REQ-039 A single sub-module sb_port_queue SHALL implement one port FIFO plus its age counter, instantiated NPORT times by a generate loop.
REQ-040 The top level SHALL contain only ingress decode, the compare/error logic, and the counters.

Verification
REQ-041 The bench SHALL cover in-order delivery: push 0x11, 0x22, 0x33 to port 2, then egress 0x11, 0x22, 0x33 on port 2 -> all flags 0, mismatch_cnt 0, idle 1.
REQ-042 The bench SHALL cover mismatch: push 0xA5 to port 1, egress 0x5A on port 1 -> err_mismatch 1 the next cycle, err_port 1, mismatch_cnt 1.
REQ-043 The bench SHALL cover overflow and full-queue pass-through: push 16 packets to port 0 then a 17th -> err_overflow 1; a separate run with push plus pop in the same cycle on a full queue -> no flag.
REQ-044 The bench SHALL cover a same-cycle empty hazard: push to port 3 and out_vld[3] in the same cycle on an empty queue -> err_unexpected 1, one entry left, idle 0.
REQ-045 The bench SHALL cover timeout: push to port 0 with no egress for 65 cycles (MAX_LAT=64) -> err_timeout 1; then err_clr -> all flags 0.
REQ-046 The bench SHALL cover flush and reset mid-traffic: 5 pending packets then flush -> idle 1 with flags unchanged; rst asserted mid-burst -> all outputs at reset values within the same cycle.
